alu_seq: RTL and testbench
==========================

# alu_seq

Micro-sequencer that drives the 8-bit ALU (DR1/DR2 latches, function select, bus output enable) through one complete register-to-register operation per request. It generates the T1–T4 phase timing, steers a register-file source onto the shared bus to load DR1, then optionally DR2, and places the ALU result back on the bus for the destination write. It sits between the instruction decoder (requester) and the ALU plus register file on the shared tri-state bus.

## Interface
Parameters: none (fixed 8-bit datapath, 4 registers, 4 phases per machine cycle).
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op_s  in  4  ALU function select; latched on accept.
- op_m  in  1  ALU mode (0 arithmetic, 1 logic); latched on accept.
- cn_in  in  1  borrow/carry for the requested op; latched on accept.
- single  in  1  1 = one-operand op, skip DR2 load; latched on accept.
- src_a  in  2  register feeding DR1; latched.
- src_b  in  2  register feeding DR2; latched.
- dst  in  2  destination register; latched.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- lddr1, lddr2  out  1  ALU DR1/DR2 load enables.
- t4  out  1  phase-4 strobe to ALU (DRs latch on its rising edge).
- nalu_bus  out  1  active-low ALU bus drive.
- s  out  4, m  out  1, cn  out  1  ALU function controls.
- reg_rd_sel  out  2, nreg_bus  out  1  register source select / active-low register bus drive.
- reg_wr_sel  out  2, reg_we  out  1  destination select / write enable (write on clk edge while high).

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC. Each non-IDLE state lasts one machine cycle = 4 clk (phase counter 0..3, phase 3 = T4).
- IDLE: start=1 at an edge → latch all op fields, go LOAD_A, phase 0. start=0 → stay.
- LOAD_A: reg_rd_sel=src_a, nreg_bus=0, lddr1=1 for all 4 cycles. After phase 3 → LOAD_B if single=0, else EXEC.
- LOAD_B: reg_rd_sel=src_b, nreg_bus=0, lddr2=1 for all 4 cycles → EXEC.
- EXEC: nalu_bus=0 all 4 cycles; reg_wr_sel=dst throughout; reg_we=1 in phase 3 only; lddr1=lddr2=0. After phase 3 → IDLE with done=1 for the following cycle.
- t4=1 exactly in phase 3 of every non-IDLE state; 0 in IDLE.
- s, m from latched op; cn = latched cn_in when m=0 and s∈{0110,0111,1011,1111}, else 0. s/m/cn hold until the next accept.
- All outputs registered. nreg_bus and nalu_bus never both 0 in any cycle; at most one of lddr1, lddr2, reg_we is high in any cycle.
- start while busy: ignored, no queuing.
- Reset values (and after rst_n=0 mid-operation, next cycle): state IDLE, busy=0, done=0, lddr1=lddr2=0, t4=0, nalu_bus=1, nreg_bus=1, reg_we=0, reg_rd_sel=reg_wr_sel=0, s=0, m=0, cn=0. Aborted op produces no reg_we and no done.

## Timing
- Accept at edge E0. Two-operand: LOAD_A cycles 1–4, LOAD_B 5–8, EXEC 9–12; busy=1 cycles 1–12; reg_we high in cycle 12 (write at E12); done=1 in cycle 13.
- Single: LOAD_A 1–4, EXEC 5–8, done cycle 9.
- DR latch points: t4 rises at E3 (DR1), E7 (DR2); bus driven by register for all of that machine cycle.
- Back-to-back: start=1 during the done cycle is accepted at its ending edge; new LOAD_A begins immediately (13-cycle period two-operand, 9 single).

## Test plan
- R1=0x35, R2=0x12, op_m=0 s=1001, src_a=1 src_b=2 dst=3 → R3=0x47 at E12, done cycle 13, busy cycles 1–12.
- Subtract: R1=0x10, R2=0x03, s=0110, cn_in=1 → cn=1, R3=0x0C; same op with s=1001, cn_in=1 → cn=0.
- Single: m=1 s=0000, R0=0xA5, dst=2 → R2=0x5A, lddr2 never asserted, done cycle 9.
- rst_n=0 at cycle 6 of an op → all outputs at reset values next cycle, dst unchanged, no done; new start afterward completes normally.
- start held high through an op: no re-accept until done cycle; second op begins cycle 14.
- Every run: assert no cycle with nreg_bus=0 and nalu_bus=0; t4 only in phase 3.

Source files
------------

// File: rtl/alu_seq.sv
// Micro-sequencer for the 8-bit ALU: runs one register-to-register operation
// per accepted request as LOAD_A -> (LOAD_B) -> EXEC, four clk phases per state.
module alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] op_s,
  input  logic       op_m,
  input  logic       cn_in,
  input  logic       single,
  input  logic [1:0] src_a,
  input  logic [1:0] src_b,
  input  logic [1:0] dst,
  output logic       busy,
  output logic       done,
  output logic       lddr1,
  output logic       lddr2,
  output logic       t4,
  output logic       nalu_bus,
  output logic [3:0] s,
  output logic       m,
  output logic       cn,
  output logic [1:0] reg_rd_sel,
  output logic       nreg_bus,
  output logic [1:0] reg_wr_sel,
  output logic       reg_we,
  output logic [1:0] dbg_state,
  output logic [1:0] dbg_phase
);

  // Request handshake: start is sampled only while idle (busy=0); a sampled
  // start is accepted at that edge, busy rises the next cycle, and any start
  // seen while busy is dropped. done pulses one cycle after the write cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    EXEC   = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic       accept;

  logic       single_q, single_d;
  logic [1:0] src_a_q, src_a_d;
  logic [1:0] src_b_q, src_b_d;
  logic [1:0] dst_q, dst_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       lddr1_q, lddr1_d;
  logic       lddr2_q, lddr2_d;
  logic       t4_q, t4_d;
  logic       nalu_q, nalu_d;
  logic       nreg_q, nreg_d;
  logic [1:0] rd_sel_q, rd_sel_d;
  logic [1:0] wr_sel_q, wr_sel_d;
  logic       we_q, we_d;
  logic [3:0] s_q, s_d;
  logic       m_q, m_d;
  logic       cn_q, cn_d;

  // Only the subtract-style arithmetic functions consume the carry input.
  function automatic logic cn_select(input logic [3:0] fs, input logic fm, input logic fc);
    logic uses_cn;
    uses_cn = (fs == 4'b0110) || (fs == 4'b0111) || (fs == 4'b1011) || (fs == 4'b1111);
    return (!fm && uses_cn) ? fc : 1'b0;
  endfunction

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d = 2'd0;
        if (start) begin
          accept  = 1'b1;
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) state_d = single_q ? EXEC : LOAD_B;
      end
      LOAD_B: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) state_d = EXEC;
      end
      EXEC: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        phase_d = 2'd0;
      end
    endcase
  end

  // Operand fields: the accepting cycle uses the raw inputs so LOAD_A outputs
  // can be registered at the same edge that latches them.
  always_comb begin
    single_d = accept ? single : single_q;
    src_a_d  = accept ? src_a  : src_a_q;
    src_b_d  = accept ? src_b  : src_b_q;
    dst_d    = accept ? dst    : dst_q;
    s_d      = accept ? op_s   : s_q;
    m_d      = accept ? op_m   : m_q;
    cn_d     = accept ? cn_select(op_s, op_m, cn_in) : cn_q;
  end

  // Outputs are decoded from the next state so every pin comes from a flop.
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_q == EXEC) && (phase_q == 2'd3);
    lddr1_d  = 1'b0;
    lddr2_d  = 1'b0;
    t4_d     = 1'b0;
    nalu_d   = 1'b1;
    nreg_d   = 1'b1;
    rd_sel_d = 2'd0;
    wr_sel_d = 2'd0;
    we_d     = 1'b0;
    case (state_d)
      LOAD_A: begin
        lddr1_d  = 1'b1;
        nreg_d   = 1'b0;
        rd_sel_d = src_a_d;
        t4_d     = (phase_d == 2'd3);
      end
      LOAD_B: begin
        lddr2_d  = 1'b1;
        nreg_d   = 1'b0;
        rd_sel_d = src_b_d;
        t4_d     = (phase_d == 2'd3);
      end
      EXEC: begin
        nalu_d   = 1'b0;
        wr_sel_d = dst_d;
        we_d     = (phase_d == 2'd3);
        t4_d     = (phase_d == 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= 2'd0;
      single_q <= 1'b0;
      src_a_q  <= 2'd0;
      src_b_q  <= 2'd0;
      dst_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lddr1_q  <= 1'b0;
      lddr2_q  <= 1'b0;
      t4_q     <= 1'b0;
      nalu_q   <= 1'b1;
      nreg_q   <= 1'b1;
      rd_sel_q <= 2'd0;
      wr_sel_q <= 2'd0;
      we_q     <= 1'b0;
      s_q      <= 4'd0;
      m_q      <= 1'b0;
      cn_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      single_q <= single_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      dst_q    <= dst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lddr1_q  <= lddr1_d;
      lddr2_q  <= lddr2_d;
      t4_q     <= t4_d;
      nalu_q   <= nalu_d;
      nreg_q   <= nreg_d;
      rd_sel_q <= rd_sel_d;
      wr_sel_q <= wr_sel_d;
      we_q     <= we_d;
      s_q      <= s_d;
      m_q      <= m_d;
      cn_q     <= cn_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign lddr1      = lddr1_q;
  assign lddr2      = lddr2_q;
  assign t4         = t4_q;
  assign nalu_bus   = nalu_q;
  assign nreg_bus   = nreg_q;
  assign reg_rd_sel = rd_sel_q;
  assign reg_wr_sel = wr_sel_q;
  assign reg_we     = we_q;
  assign s          = s_q;
  assign m          = m_q;
  assign cn         = cn_q;
  assign dbg_state  = state_q;
  assign dbg_phase  = phase_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: models the register file, bus and ALU around the DUT and
// checks every cycle of each operation against the machine-cycle timing rules.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] op_s;
  logic       op_m;
  logic       cn_in;
  logic       single;
  logic [1:0] src_a, src_b, dst;
  logic       busy, done, lddr1, lddr2, t4, nalu_bus, m, cn, nreg_bus, reg_we;
  logic [3:0] s;
  logic [1:0] reg_rd_sel, reg_wr_sel, dbg_state, dbg_phase;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_q[$];
  logic [7:0] regs[4];
  logic [7:0] dr1, dr2, alu_out, bus_v;
  logic       pre_we;
  logic [1:0] pre_sel;
  logic [7:0] pre_val;
  logic [17:0] obs_vec;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_s(op_s), .op_m(op_m),
    .cn_in(cn_in), .single(single), .src_a(src_a), .src_b(src_b), .dst(dst),
    .busy(busy), .done(done), .lddr1(lddr1), .lddr2(lddr2), .t4(t4),
    .nalu_bus(nalu_bus), .s(s), .m(m), .cn(cn), .reg_rd_sel(reg_rd_sel),
    .nreg_bus(nreg_bus), .reg_wr_sel(reg_wr_sel), .reg_we(reg_we),
    .dbg_state(dbg_state), .dbg_phase(dbg_phase)
  );

  always #5 clk = ~clk;

  assign obs_vec = {busy, done, lddr1, lddr2, t4, nalu_bus, nreg_bus,
                    reg_rd_sel, reg_wr_sel, reg_we, s, m, cn};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU: only needs to be deterministic and operand-sensitive.
  function automatic logic [7:0] alu_f(input logic [3:0] fs, input logic fm, input logic fc,
                                       input logic [7:0] a, input logic [7:0] b);
    if (fm) begin
      case (fs)
        4'b0000: return ~a;
        4'b0110: return a ^ b;
        4'b1011: return a & b;
        4'b1110: return a | b;
        4'b1111: return a;
        default: return ~(a | b);
      endcase
    end
    case (fs)
      4'b1001: return a + b + {7'd0, fc};
      4'b0110: return a - b - {7'd0, fc};
      default: return a + {7'd0, fc};
    endcase
  endfunction

  always_comb begin
    alu_out = alu_f(s, m, cn, dr1, dr2);
    if (!nreg_bus)      bus_v = regs[reg_rd_sel];
    else if (!nalu_bus) bus_v = alu_out;
    else                bus_v = 8'h00;
  end

  always @(posedge t4) begin
    if (lddr1) dr1 <= bus_v;
    if (lddr2) dr2 <= bus_v;
  end

  // Register file plus write scoreboard.
  always @(posedge clk) begin
    if (pre_we) regs[pre_sel] <= pre_val;
    if (reg_we) begin
      if (exp_q.size() == 0) check("unexp_we", 32'd1, 32'd0);
      else check("wr", {22'd0, reg_wr_sel, bus_v}, {22'd0, exp_q.pop_front()});
      regs[reg_wr_sel] <= bus_v;
    end
  end

  always @(negedge clk) begin
    check("bus_excl", {31'd0, nreg_bus | nalu_bus}, 32'd1);
    check("ld_excl", {31'd0, (int'(lddr1) + int'(lddr2) + int'(reg_we)) <= 1}, 32'd1);
  end

  function automatic logic [17:0] pack(input logic bz, input logic dn, input logic l1,
      input logic l2, input logic t, input logic na, input logic nr, input logic [1:0] rd,
      input logic [1:0] wr, input logic we, input logic [3:0] fs, input logic fm, input logic fc);
    return {bz, dn, l1, l2, t, na, nr, rd, wr, we, fs, fm, fc};
  endfunction

  // Expected pins in cycle c after the accepting edge (cycle 1 = first LOAD_A).
  function automatic logic [17:0] exp_vec(input int c, input logic sg, input logic [1:0] sa,
      input logic [1:0] sb, input logic [1:0] ds, input logic [3:0] fs, input logic fm,
      input logic fc);
    int   mc;
    logic t;
    mc = (c - 1) / 4;
    t  = ((c - 1) % 4) == 3;
    if (c == (sg ? 9 : 13))
      return pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, fs, fm, fc);
    if (mc == 0)
      return pack(1'b1, 1'b0, 1'b1, 1'b0, t, 1'b1, 1'b0, sa, 2'd0, 1'b0, fs, fm, fc);
    if (mc == 1 && !sg)
      return pack(1'b1, 1'b0, 1'b0, 1'b1, t, 1'b1, 1'b0, sb, 2'd0, 1'b0, fs, fm, fc);
    return pack(1'b1, 1'b0, 1'b0, 1'b0, t, 1'b0, 1'b1, 2'd0, ds, t, fs, fm, fc);
  endfunction

  localparam logic [17:0] RST_VEC = 18'b0000011_00_00_0_0000_0_0;

  task automatic preload(input logic [1:0] sel, input logic [7:0] val);
    pre_we = 1'b1; pre_sel = sel; pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("idle", {30'd0, busy, done}, 32'd0);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the done
  // cycle (or one cycle after an abort), so a following call is back-to-back.
  task automatic run_op(input logic [3:0] os, input logic om, input logic icn, input logic isg,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] ds,
                        input logic keep, input int abort_at);
    logic       ecn;
    logic [7:0] res;
    int         n;
    op_s = os; op_m = om; cn_in = icn; single = isg;
    src_a = sa; src_b = sb; dst = ds; start = 1'b1;
    ecn = (!om && (os == 4'b0110 || os == 4'b0111 || os == 4'b1011 || os == 4'b1111)) ? icn : 1'b0;
    res = alu_f(os, om, ecn, regs[sa], regs[sb]);
    if (abort_at == 0) exp_q.push_back({ds, res});
    n = isg ? 9 : 13;
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (!keep) start = 1'b0;
      check($sformatf("cyc%0d_s%b_m%b_sg%b", c, os, om, isg), {14'd0, obs_vec},
            {14'd0, exp_vec(c, isg, sa, sb, ds, os, om, ecn)});
      if (c == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_rst", {14'd0, obs_vec}, {14'd0, RST_VEC});
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [7:0] saved;
    logic [3:0] os;
    logic       om, sg, keep;
    int         gap;
    rst_n = 1'b0; start = 1'b0; op_s = 4'd0; op_m = 1'b0; cn_in = 1'b0; single = 1'b0;
    src_a = 2'd0; src_b = 2'd0; dst = 2'd0; pre_we = 1'b0; pre_sel = 2'd0; pre_val = 8'd0;
    dr1 = 8'd0; dr2 = 8'd0;
    repeat (3) @(negedge clk);
    check("reset", {14'd0, obs_vec}, {14'd0, RST_VEC});
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", {14'd0, obs_vec}, {14'd0, RST_VEC});
    for (int i = 0; i < 4; i++) preload(2'(i), 8'h00);

    // Add R1+R2 -> R3.
    preload(2'd1, 8'h35); preload(2'd2, 8'h12);
    run_op(4'b1001, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd3, 1'b0, 0);
    check("r3_add", {24'd0, regs[3]}, 32'h47);
    idle(2);

    // Subtract with borrow, then add with carry forced off.
    preload(2'd1, 8'h10); preload(2'd2, 8'h03);
    run_op(4'b0110, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 2'd3, 1'b0, 0);
    check("r3_sub", {24'd0, regs[3]}, 32'h0C);
    idle(1);
    run_op(4'b1001, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 2'd3, 1'b0, 0);
    check("r3_add_nocn", {24'd0, regs[3]}, 32'h13);
    idle(1);

    // Single-operand invert.
    preload(2'd0, 8'hA5);
    run_op(4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 2'd2, 1'b0, 0);
    check("r2_not", {24'd0, regs[2]}, 32'h5A);
    idle(1);

    // Abort during LOAD_B, then a normal op.
    saved = regs[3];
    run_op(4'b1001, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 2'd3, 1'b0, 6);
    idle(15);
    check("abort_dst", {24'd0, regs[3]}, {24'd0, saved});
    run_op(4'b1001, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd3, 1'b0, 0);
    check("r3_after_abort", {24'd0, regs[3]}, 32'hB5);

    // start held through an op: next accept only at the done-cycle edge.
    run_op(4'b1110, 1'b1, 1'b0, 1'b0, 2'd2, 2'd3, 2'd1, 1'b1, 0);
    run_op(4'b1011, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0, 0);
    idle(1);

    // Randomized ops with random gaps and register contents.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0)
        for (int r = 0; r < 4; r++) preload(2'(r), 8'($urandom));
      sg = 1'($urandom_range(0, 1));
      om = 1'($urandom_range(0, 1));
      os = 4'($urandom_range(0, 15));
      if (sg) begin
        if (om) os = $urandom_range(0, 1) ? 4'b1111 : 4'b0000;
        else if (os == 4'b1001 || os == 4'b0110) os = 4'b0111;
      end
      gap  = $urandom_range(0, 2);
      keep = (gap == 0) && (k != 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_op(os, om, 1'($urandom_range(0, 1)), sg, 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), keep, 0);
      if (!keep) start = 1'b0;
      if (gap > 0) idle(gap);
    end
    start = 1'b0;
    idle(3);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
